vga_scanout_reader: RTL

Read-side scan-out engine for the 160x120, 3-bit-per-pixel video memory. It generates 640x480@60 VGA timing from a 25.175 MHz pixel clock and issues `read_address` into the memory's combinational read port with 4x pixel/line replication. It registers the returned `data_out` and drives VGA RGB and sync pins, with all outputs aligned by a fixed 2-cycle pipeline. It is the consumer counterpart of the pixel writers that fill video memory through its write port.

---
 rtl/vga_scanout_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_scanout_reader.sv
// 640x480@60 VGA scan-out engine for a 160x120x3bpp framebuffer with 4x pixel/line replication.
// Two-stage pipeline: counters -> registered read address -> registered RGB and sync outputs.
module vga_scanout_reader #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic        clk_pixel,
    input  logic        reset,
    output logic [15:0] read_address,
    input  logic [2:0]  data_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        video_active,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned AW       = 16;
    localparam int unsigned FB_WIDTH = 160;
    // Row stride 160 = 128 + 32, so the row multiply is two shifts and an add.
    localparam int unsigned FB_SH_HI = $clog2(FB_WIDTH) - 1;
    localparam int unsigned FB_SH_LO = $clog2(FB_WIDTH - (1 << FB_SH_HI));
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic [AW-1:0] r_read_address;
    logic          r_active1;
    logic          r_hs1;
    logic          r_vs1;
    logic          r_first1;

    logic [3:0]    r_vga_r;
    logic [3:0]    r_vga_g;
    logic [3:0]    r_vga_b;
    logic          r_vga_hsync;
    logic          r_vga_vsync;
    logic          r_video_active;
    logic          r_frame_start;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_active0;
    logic          w_hs0;
    logic          w_vs0;
    logic          w_first0;
    logic [AW-1:0] w_fb_x;
    logic [AW-1:0] w_fb_y;
    logic [AW-1:0] w_addr0;

    assign w_h_last  = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last  = (r_v_cnt == VW'(V_TOTAL - 1));
    assign w_active0 = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign w_hs0     = !((r_h_cnt >= HW'(HS_START)) && (r_h_cnt <= HW'(HS_END)));
    assign w_vs0     = !((r_v_cnt >= VW'(VS_START)) && (r_v_cnt <= VW'(VS_END)));
    assign w_first0  = (r_h_cnt == '0) && (r_v_cnt == '0);

    assign w_fb_x    = AW'(r_h_cnt >> SCALE_SHIFT);
    assign w_fb_y    = AW'(r_v_cnt >> SCALE_SHIFT);
    assign w_addr0   = (w_fb_y << FB_SH_HI) + (w_fb_y << FB_SH_LO) + w_fb_x;

    // Stage 0: free-running raster position.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Stage 1: memory address plus timing flags carried alongside it.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_read_address <= '0;
            r_active1      <= 1'b0;
            r_hs1          <= 1'b1;
            r_vs1          <= 1'b1;
            r_first1       <= 1'b0;
        end else begin
            r_read_address <= w_active0 ? w_addr0 : '0;
            r_active1      <= w_active0;
            r_hs1          <= w_hs0;
            r_vs1          <= w_vs0;
            r_first1       <= w_first0;
        end
    end

    // Stage 2: colour expansion with blanking, and aligned sync outputs.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_vga_r        <= 4'h0;
            r_vga_g        <= 4'h0;
            r_vga_b        <= 4'h0;
            r_vga_hsync    <= 1'b1;
            r_vga_vsync    <= 1'b1;
            r_video_active <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_vga_r        <= r_active1 ? {4{data_in[2]}} : 4'h0;
            r_vga_g        <= r_active1 ? {4{data_in[1]}} : 4'h0;
            r_vga_b        <= r_active1 ? {4{data_in[0]}} : 4'h0;
            r_vga_hsync    <= r_hs1;
            r_vga_vsync    <= r_vs1;
            r_video_active <= r_active1;
            r_frame_start  <= r_first1;
        end
    end

    assign read_address = r_read_address;
    assign vga_r        = r_vga_r;
    assign vga_g        = r_vga_g;
    assign vga_b        = r_vga_b;
    assign vga_hsync    = r_vga_hsync;
    assign vga_vsync    = r_vga_vsync;
    assign video_active = r_video_active;
    assign frame_start  = r_frame_start;

endmodule
